// File: rtl/trigger_delay_gen_if.sv
// trigger_delay_gen_if: trigger, config and status bundle
// between the capture controller and the delay generator.
interface trigger_delay_gen_if #(
  parameter int pDELAY_WIDTH   = 24,
  parameter int pPULSE_WIDTH   = 8,
  parameter int pHOLDOFF_WIDTH = 16,
  parameter int pCOUNT_WIDTH   = 16
);

  logic                      trigger_in;
  logic                      armed_and_ready;
  logic [pDELAY_WIDTH-1:0]   delay;
  logic [pPULSE_WIDTH-1:0]   pulse_width;
  logic [pHOLDOFF_WIDTH-1:0] holdoff;
  logic                      clear_counts;

  logic                      trig_out;
  logic                      busy;
  logic [pCOUNT_WIDTH-1:0]   trig_count;
  logic [pCOUNT_WIDTH-1:0]   missed_count;
  logic [7:0]                debug;

  modport master (
    output trigger_in,
    output armed_and_ready,
    output delay,
    output pulse_width,
    output holdoff,
    output clear_counts,
    input  trig_out,
    input  busy,
    input  trig_count,
    input  missed_count,
    input  debug
  );

  modport slave (
    input  trigger_in,
    input  armed_and_ready,
    input  delay,
    input  pulse_width,
    input  holdoff,
    input  clear_counts,
    output trig_out,
    output busy,
    output trig_count,
    output missed_count,
    output debug
  );

endinterface

// File: rtl/trigger_delay_gen.sv
// trigger_delay_gen: delays an accepted trigger, stretches it
// into a pulse, then holds off; counts accepted/missed triggers.
module trigger_delay_gen #(
  parameter int pDELAY_WIDTH   = 24,
  parameter int pPULSE_WIDTH   = 8,
  parameter int pHOLDOFF_WIDTH = 16,
  parameter int pCOUNT_WIDTH   = 16
) (
  input  logic              adc_sampleclk,
  input  logic              reset_n,
  trigger_delay_gen_if.slave bus
);

  localparam int pCW_A =
    (pDELAY_WIDTH > pPULSE_WIDTH) ?
    pDELAY_WIDTH : pPULSE_WIDTH;
  localparam int pCNT_WIDTH =
    (pCW_A > pHOLDOFF_WIDTH) ?
    pCW_A : pHOLDOFF_WIDTH;

  localparam logic [pCNT_WIDTH-1:0] CNT_ONE =
    {{(pCNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pCOUNT_WIDTH-1:0] STAT_ONE =
    {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [pCNT_WIDTH-1:0]   cnt_q;
  logic [pCNT_WIDTH-1:0]   cnt_d;

  logic                    trig_out_q;
  logic                    trig_out_d;
  logic                    busy_q;
  logic                    busy_d;
  logic [pCOUNT_WIDTH-1:0] trig_count_q;
  logic [pCOUNT_WIDTH-1:0] trig_count_d;
  logic [pCOUNT_WIDTH-1:0] missed_count_q;
  logic [pCOUNT_WIDTH-1:0] missed_count_d;

  logic [pCNT_WIDTH-1:0]   delay_ext;
  logic [pCNT_WIDTH-1:0]   holdoff_ext;
  logic [pCNT_WIDTH-1:0]   pw_load;
  logic                    cnt_le_one;
  logic                    trig_sat;
  logic                    missed_sat;
  logic                    accept;
  logic                    miss;

  // Settings are unsigned; widen them to the shared counter width.
  assign delay_ext   = pCNT_WIDTH'(bus.delay);
  assign holdoff_ext = pCNT_WIDTH'(bus.holdoff);

  // A zero pulse width still produces a single-cycle pulse.
  assign pw_load = (bus.pulse_width == '0) ?
                   '0 :
                   pCNT_WIDTH'(bus.pulse_width) - CNT_ONE;

  assign cnt_le_one = (cnt_q <= CNT_ONE);
  assign trig_sat   = &trig_count_q;
  assign missed_sat = &missed_count_q;

  // Trigger classification depends only on the current state.
  assign accept = bus.armed_and_ready & bus.trigger_in &
                  (state_q == IDLE);
  assign miss   = bus.armed_and_ready & bus.trigger_in &
                  (state_q != IDLE);

  // State and counter registers with synchronous reset.
  always_ff @(posedge adc_sampleclk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      trig_out_q     <= 1'b0;
      busy_q         <= 1'b0;
      trig_count_q   <= '0;
      missed_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      trig_out_q     <= trig_out_d;
      busy_q         <= busy_d;
      trig_count_q   <= trig_count_d;
      missed_count_q <= missed_count_d;
    end
  end

  // Next-state and down-counter sequencing; disarm wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.armed_and_ready) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.trigger_in) begin
            if (delay_ext == '0) begin
              state_d = PULSE;
              cnt_d   = pw_load;
            end else begin
              state_d = DELAY;
              cnt_d   = delay_ext;
            end
          end
        end
        DELAY: begin
          if (cnt_le_one) begin
            state_d = PULSE;
            cnt_d   = pw_load;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            if (holdoff_ext == '0) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = HOLDOFF;
              cnt_d   = holdoff_ext;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        HOLDOFF: begin
          if (cnt_le_one) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Registered outputs follow the next state; counters saturate.
  always_comb begin
    trig_out_d     = (state_d == PULSE);
    busy_d         = (state_d != IDLE);
    trig_count_d   = trig_count_q;
    missed_count_d = missed_count_q;
    if (bus.clear_counts) begin
      trig_count_d   = '0;
      missed_count_d = '0;
    end else begin
      if (accept && !trig_sat)
        trig_count_d = trig_count_q + STAT_ONE;
      if (miss && !missed_sat)
        missed_count_d = missed_count_q + STAT_ONE;
    end
  end

  assign bus.trig_out     = trig_out_q;
  assign bus.busy         = busy_q;
  assign bus.trig_count   = trig_count_q;
  assign bus.missed_count = missed_count_q;
  assign bus.debug        = {
    (cnt_q == '0),
    missed_sat,
    trig_sat,
    bus.trigger_in,
    bus.armed_and_ready,
    trig_out_q,
    state_q
  };

endmodule
